// File: rtl/mac_accum_stage.sv
// Dot-product accumulator behind the free-running multiplier, with a credit-guarded result FIFO.
// Define MAC_SAT_EN to clamp out-of-range sums to 64 bits and flag them per entry on out_ovf.
module mac_accum_stage #(
  parameter int LAT   = 2,
  parameter int ACC_W = 80,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_first,
  input  logic        in_last,
  input  logic [63:0] prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_ovf,
  output logic        busy
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CRED_W = $clog2(DEPTH + LAT + 1);

  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_first_q, tag_first_d;
  logic [LAT-1:0] tag_last_q, tag_last_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;

  logic [63:0]       mem_q [DEPTH];
  logic [63:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [CRED_W-1:0] lasts_d;

  logic        accept;
  logic        consume;
  logic        push;
  logic        pop;
  logic [63:0] push_data;

  assign accept   = in_valid & in_ready;
  assign consume  = tag_v_q[LAT-1];
  assign push     = consume & tag_last_q[LAT-1];
  assign out_valid = (count_q != '0);
  assign pop      = out_valid & out_ready;
  assign prod_ext = $signed(prod);
  assign sum      = (tag_first_q[LAT-1] ? '0 : acc_q) + prod_ext;

  // The credit register already counts every last in flight, so in_ready needs no further gating.
  assign in_ready = (credit_q < CRED_W'(DEPTH));
  assign busy     = (|tag_v_q) | out_valid;
  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef MAC_SAT_EN
  logic             in_range;
  logic             push_ovf;
  logic [DEPTH-1:0] ovf_q, ovf_d;

  assign in_range  = (&sum[ACC_W-1:63]) | ~(|sum[ACC_W-1:63]);
  assign push_ovf  = ~in_range;
  assign push_data = in_range ? sum[63:0] :
                     (sum[ACC_W-1] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF);
  assign out_ovf   = out_valid & ovf_q[rd_ptr_q];

  always_comb begin
    ovf_d = ovf_q;
    if (push) ovf_d[wr_ptr_q] = push_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end
`else
  assign push_data = sum[63:0];
  assign out_ovf   = 1'b0;
`endif

  always_comb begin
    tag_v_d     = '0;
    tag_first_d = '0;
    tag_last_d  = '0;
    tag_v_d[0]     = accept;
    tag_first_d[0] = accept & in_first;
    tag_last_d[0]  = accept & in_last;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]     = tag_v_q[i-1];
      tag_first_d[i] = tag_first_q[i-1];
      tag_last_d[i]  = tag_last_q[i-1];
    end

    acc_d = acc_q;
    if (consume) acc_d = tag_last_q[LAT-1] ? '0 : sum;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    lasts_d = '0;
    for (int i = 0; i < LAT; i++) lasts_d = lasts_d + CRED_W'(tag_v_d[i] & tag_last_d[i]);
    credit_d = CRED_W'(count_d) + lasts_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q     <= '0;
      tag_first_q <= '0;
      tag_last_q  <= '0;
      acc_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      credit_q    <= '0;
    end else begin
      tag_v_q     <= tag_v_d;
      tag_first_q <= tag_first_d;
      tag_last_q  <= tag_last_d;
      acc_q       <= acc_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      credit_q    <= credit_d;
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == CNT_W'(DEPTH) && !pop));

endmodule

// File: tb/tb_mac_accum_stage.sv
// Directed bench for mac_accum_stage; a two-stage behavioural multiplier feeds prod.
// Expected values follow MAC_SAT_EN the same way as the design build.
module tb_mac_accum_stage;

  localparam int LAT   = 2;
  localparam int ACC_W = 80;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_first, in_last;
  logic        in_ready;
  logic [63:0] prod;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        out_ovf;
  logic        busy;

  logic signed [31:0] x, y;
  logic signed [63:0] p0, p1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] rx_q[$];
  logic [64:0] exp_q[$];

  typedef struct {
    logic        first;
    logic        last;
    int          xv;
    int          yv;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[9];

  mac_accum_stage #(.LAT(LAT), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .prod(prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running multiplier: x/y in cycle t gives prod in cycle t+LAT.
  always @(posedge clk) begin
    p0 <= $signed(x) * $signed(y);
    p1 <= p0;
  end
  assign prod = p1;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) rx_q.push_back({out_ovf, out_data});

  task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic l, input int xv, input int yv);
    int   k;
    logic r;
    in_valid = 1'b1; in_first = f; in_last = l; x = xv; y = yv;
    k = 0;
    do begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      k++;
    end while (!r && k < 50);
    if (!r) checkOutput("accept_timeout", 65'd0, 65'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 100);
    checkOutput("drain", {64'd0, busy}, 65'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [64:0] expectRes(input logic signed [79:0] s);
`ifdef MAC_SAT_EN
    logic signed [79:0] maxv;
    maxv = 80'sd9223372036854775807;
    if (s > maxv)          return {1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
    if (s < (-maxv - 1))   return {1'b1, 64'h8000_0000_0000_0000};
`endif
    return {1'b0, s[63:0]};
  endfunction

  initial begin
    logic signed [79:0] m;
    longint             p;
    int                 idx, len, k;
    logic               r;

    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; x = '0; y = '0;

    #12;
    checkOutput("reset_out_valid", {64'd0, out_valid}, 65'd0);
    checkOutput("reset_out_data",  {1'b0, out_data}, 65'd0);
    checkOutput("reset_out_ovf",   {64'd0, out_ovf}, 65'd0);
    checkOutput("reset_busy",      {64'd0, busy}, 65'd0);
    checkOutput("reset_in_ready",  {64'd0, in_ready}, 65'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat latency: accepted in cycle t, visible in cycle t+LAT+1.
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; x = 3; y = 4;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    @(negedge clk); checkOutput("lat_t+1_valid", {64'd0, out_valid}, 65'd0);
    @(negedge clk); checkOutput("lat_t+2_valid", {64'd0, out_valid}, 65'd0);
    @(negedge clk); checkOutput("lat_t+3_valid", {64'd0, out_valid}, 65'd1);
    checkOutput("lat_t+3_data", {out_ovf, out_data}, {1'b0, 64'd12});
    @(posedge clk); #1;
    drain();
    rx_q.delete();

    tbl[0] = '{1'b1, 1'b0, 1, 1, 64'd0};
    tbl[1] = '{1'b0, 1'b0, 1, 2, 64'd0};
    tbl[2] = '{1'b0, 1'b0, 1, 3, 64'd0};
    tbl[3] = '{1'b0, 1'b1, -2, 5, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[4] = '{1'b1, 1'b1, 7, -6, 64'hFFFF_FFFF_FFFF_FFD6};
    tbl[5] = '{1'b0, 1'b1, 100, 100, 64'd10000};
    tbl[6] = '{1'b1, 1'b0, 32'sh8000_0000, 2, 64'd0};
    tbl[7] = '{1'b0, 1'b1, 1, 5, 64'hFFFF_FFFF_0000_0005};
    tbl[8] = '{1'b1, 1'b1, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    for (int i = 0; i < 9; i++) applyStimulus(tbl[i].first, tbl[i].last, tbl[i].xv, tbl[i].yv);
    idle(1);
    drain();
    checkOutput("table_count", 65'(rx_q.size()), 65'd5);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].last) begin
        if (rx_q.size() > 0) checkOutput($sformatf("table_%0d", i), rx_q.pop_front(), {1'b0, tbl[i].exp});
      end
    end
    rx_q.delete();

    // Credit limit: the fifth beat waits until the consumer pops.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 6); in_first = 1'b1; in_last = 1'b1; x = idx + 1; y = 10;
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r && idx < 6) idx++;
    end
    @(negedge clk);
    checkOutput("credit_accepted", 65'(idx), 65'd4);
    checkOutput("credit_in_ready", {64'd0, in_ready}, 65'd0);
    checkOutput("hold_head_a", {out_ovf, out_data}, {1'b0, 64'd10});
    @(negedge clk);
    checkOutput("hold_head_b", {out_ovf, out_data}, {1'b0, 64'd10});
    @(posedge clk); #1;
    out_ready = 1'b1;
    k = 0;
    while (idx < 6 && k < 40) begin
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; x = idx + 1; y = 10;
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) idx++;
      k++;
    end
    checkOutput("credit_all_accepted", 65'(idx), 65'd6);
    idle(1);
    drain();
    checkOutput("credit_rx_count", 65'(rx_q.size()), 65'd6);
    for (int i = 0; i < 6; i++)
      if (rx_q.size() > 0) checkOutput($sformatf("credit_order_%0d", i), rx_q.pop_front(), 65'((i + 1) * 10));
    rx_q.delete();

    // Sums beyond the signed 64-bit range.
    applyStimulus(1'b1, 1'b0, 32'sh8000_0000, 32'sh8000_0000);
    applyStimulus(1'b0, 1'b1, 32'sh8000_0000, 32'sh8000_0000);
    applyStimulus(1'b1, 1'b0, 32'sh8000_0000, 32'sh8000_0000);
    applyStimulus(1'b0, 1'b1, 32'sh8000_0000, 32'sh8000_0000);
    applyStimulus(1'b1, 1'b0, 32'sh8000_0000, 32'sh7FFF_FFFF);
    applyStimulus(1'b0, 1'b0, 32'sh8000_0000, 32'sh7FFF_FFFF);
    applyStimulus(1'b0, 1'b1, 32'sh8000_0000, 32'sh7FFF_FFFF);
    idle(1);
    drain();
    checkOutput("ovf_count", 65'(rx_q.size()), 65'd3);
`ifdef MAC_SAT_EN
    exp_q.push_back({1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    exp_q.push_back({1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    exp_q.push_back({1'b1, 64'h8000_0000_0000_0000});
`else
    exp_q.push_back({1'b0, 64'h8000_0000_0000_0000});
    exp_q.push_back({1'b0, 64'h8000_0000_0000_0000});
    exp_q.push_back({1'b0, 64'h4000_0001_8000_0000});
`endif
    for (int i = 0; i < 3; i++)
      if (rx_q.size() > 0) checkOutput($sformatf("ovf_%0d", i), rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();

    // Asynchronous reset with one stored result and two beats in flight.
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 3, 3);
    idle(4);
    @(negedge clk);
    checkOutput("pre_reset_valid", {64'd0, out_valid}, 65'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2, 2);
    applyStimulus(1'b0, 1'b0, 2, 2);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid",    {64'd0, out_valid}, 65'd0);
    checkOutput("async_rst_busy",     {64'd0, busy}, 65'd0);
    checkOutput("async_rst_in_ready", {64'd0, in_ready}, 65'd1);
    checkOutput("async_rst_data",     {out_ovf, out_data}, 65'd0);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 5, 5);
    idle(1);
    drain();
    checkOutput("post_rst_count", 65'(rx_q.size()), 65'd1);
    if (rx_q.size() > 0) checkOutput("post_rst_data", rx_q.pop_front(), 65'd25);
    rx_q.delete();

    // Gapped random beats against a wide signed reference sum.
    m = '0;
    for (int s = 0; s < 5; s++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        idx = $urandom; k = $urandom;
        p = longint'(idx) * longint'(k);
        m = ((b == 0) ? 80'sd0 : m) + p;
        if (b == len - 1) exp_q.push_back(expectRes(m));
        applyStimulus(b == 0, b == len - 1, idx, k);
        idle(2);
      end
    end
    drain();
    checkOutput("rand_count", 65'(rx_q.size()), 65'(exp_q.size()));
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (rx_q.size() > 0) checkOutput($sformatf("rand_%0d", i), rx_q.pop_front(), exp_q.pop_front());
      else void'(exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
